// File: rtl/emi_initiator.sv
// rtl/emi_initiator.sv - EMI requester executing cache-line bursts and single-beat accesses
module emi_initiator #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rnw,
  input  logic              cmd_burst,
  input  logic [31:0]       cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [7:0]        cmd_bws,
  input  logic [63:0]       wr_data,
  output logic [BEAT_W-1:0] wr_beat,
  output logic              rd_valid,
  output logic [63:0]       rd_data,
  output logic [BEAT_W-1:0] rd_beat,
  output logic              done,
  output logic              err_spurious,
  output logic [31:0]       emi_addr,
  output logic [1:0]        emi_size,
  output logic              emi_req,
  output logic              emi_rnw,
  output logic [7:0]        emi_bws,
  output logic [63:0]       emi_wdata,
  input  logic [63:0]       emi_rdata,
  input  logic              emi_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;
  logic              burst_q;
  logic              last_beat;

  // A single-beat command only ever has beat 0; a burst ends on the final beat index.
  assign last_beat = burst_q ? (beat_cnt == BEAT_W'(BEATS - 1)) : (beat_cnt == '0);

  // Read beats and write data pass straight through; the beat counter indexes both directions.
  assign rd_valid  = emi_valid && emi_req && emi_rnw;
  assign rd_data   = emi_rdata;
  assign rd_beat   = beat_cnt;
  assign wr_beat   = beat_cnt;
  assign emi_wdata = wr_data;

  // Request sequencer: capture a command in IDLE, hold the EMI request fields until the last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      burst_q      <= 1'b0;
      cmd_ready    <= 1'b1;
      emi_req      <= 1'b0;
      emi_rnw      <= 1'b0;
      emi_addr     <= '0;
      emi_size     <= '0;
      emi_bws      <= '0;
      done         <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      done         <= 1'b0;
      // A valid with no request outstanding is flagged and otherwise ignored.
      err_spurious <= emi_valid && !emi_req;
      case (state)
        IDLE: begin
          // cmd_ready is high throughout IDLE, including the done cycle, so the
          // request gap after completion is exactly that one cycle.
          if (cmd_valid) begin
            state     <= BUSY;
            cmd_ready <= 1'b0;
            emi_req   <= 1'b1;
            emi_rnw   <= cmd_rnw;
            burst_q   <= cmd_burst;
            beat_cnt  <= '0;
            if (cmd_burst) begin
              emi_addr <= {cmd_addr[31:5], 5'b0};
              emi_size <= 2'b11;
              emi_bws  <= 8'hFF;
            end else begin
              emi_addr <= cmd_addr;
              emi_size <= cmd_size;
              emi_bws  <= cmd_bws;
            end
          end
        end
        BUSY: begin
          // Beats advance only on emi_valid; stalls of any length simply hold.
          if (emi_valid) begin
            if (last_beat) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              emi_req   <= 1'b0;
              done      <= 1'b1;
              beat_cnt  <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emi_initiator.sv
// tb/tb_emi_initiator.sv - self-checking bench for emi_initiator against a transaction-level model
module tb_emi_initiator;
  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid, cmd_ready, cmd_rnw, cmd_burst;
  logic [31:0]       cmd_addr;
  logic [1:0]        cmd_size;
  logic [7:0]        cmd_bws;
  logic [63:0]       wr_data;
  logic [BEAT_W-1:0] wr_beat, rd_beat;
  logic              rd_valid, done, err_spurious;
  logic [63:0]       rd_data;
  logic [31:0]       emi_addr;
  logic [1:0]        emi_size;
  logic              emi_req, emi_rnw;
  logic [7:0]        emi_bws;
  logic [63:0]       emi_wdata, emi_rdata;
  logic              emi_valid;

  emi_initiator #(.BEATS(BEATS), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_burst(cmd_burst),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_bws(cmd_bws),
    .wr_data(wr_data), .wr_beat(wr_beat),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_beat(rd_beat),
    .done(done), .err_spurious(err_spurious),
    .emi_addr(emi_addr), .emi_size(emi_size), .emi_req(emi_req), .emi_rnw(emi_rnw),
    .emi_bws(emi_bws), .emi_wdata(emi_wdata), .emi_rdata(emi_rdata), .emi_valid(emi_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rnw;
    logic             burst;
    logic [31:0]      addr;
    logic [1:0]       size;
    logic [7:0]       bws;
    logic [3:0][63:0] d;
  } cmd_t;

  cmd_t        cq[$];
  logic [7:0]  mem [int unsigned];
  int          n_checks = 0;
  int          n_fail = 0;

  // transaction-level model
  bit          m_busy, m_done, m_spur;
  int          m_beats, m_total;
  cmd_t        m_cmd;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  logic [7:0]  m_bws;
  int          valid_pct = 100;
  bit          force_valid = 0;

  // monitors
  logic [63:0] rd_log [4];
  int          err_cnt = 0, done_cnt = 0, low_run = 0, last_gap = -1, first_rd_beat = -1;
  bit          seen_req = 0, prev_req = 0;
  logic [31:0] first_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // byte lane i of a doubleword lands at base + (i ^ 3): bytes big-endian within each 32-bit word
  function automatic int unsigned lane_addr(input logic [31:0] base, input int lane);
    return {base[31:3], 3'b000} + 32'(lane ^ 3);
  endfunction

  function automatic logic [63:0] mem_rd64(input logic [31:0] base);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) begin
      int unsigned a = lane_addr(base, i);
      if (!mem.exists(a)) mem[a] = 8'($urandom);
      v[i*8 +: 8] = mem[a];
    end
    return v;
  endfunction

  function automatic void mem_wr64(input logic [31:0] base, input logic [63:0] data, input logic [7:0] bws);
    for (int i = 0; i < 8; i++)
      if (bws[i]) mem[lane_addr(base, i)] = data[i*8 +: 8];
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] bws);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{bws[i]}};
    return m;
  endfunction

  function automatic cmd_t mk(input bit rnw, input bit burst, input logic [31:0] addr,
                              input logic [1:0] size, input logic [7:0] bws);
    cmd_t c;
    c.rnw = rnw; c.burst = burst; c.addr = addr; c.size = size; c.bws = bws;
    for (int i = 0; i < 4; i++) c.d[i] = {$urandom, $urandom};
    return c;
  endfunction

  task automatic check_outputs();
    if (!reset) begin
      chk("rst_req", emi_req, 0);     chk("rst_ready", cmd_ready, 1);
      chk("rst_done", done, 0);       chk("rst_err", err_spurious, 0);
      chk("rst_rd_valid", rd_valid, 0); chk("rst_addr", emi_addr, 0);
      chk("rst_size", emi_size, 0);   chk("rst_bws", emi_bws, 0);
      chk("rst_rnw", emi_rnw, 0);
      prev_req = 0;
    end else begin
      chk("req", emi_req, m_busy);
      chk("ready", cmd_ready, !m_busy);
      chk("done", done, m_done);
      chk("err_spurious", err_spurious, m_spur);
      chk("rd_valid", rd_valid, emi_valid && m_busy && m_cmd.rnw);
      if (m_busy) begin
        chk("emi_addr", emi_addr, m_addr);
        chk("emi_size", emi_size, m_size);
        chk("emi_bws", emi_bws, m_bws);
        chk("emi_rnw", emi_rnw, m_cmd.rnw);
        if (m_cmd.rnw) begin
          if (emi_valid) begin
            chk("rd_data", rd_data, emi_rdata);
            chk("rd_beat", rd_beat, m_beats);
          end
        end else begin
          chk("wr_beat", wr_beat, m_beats);
          chk("emi_wdata", emi_wdata, wr_data);
          if (emi_valid) mem_wr64(emi_addr + 32'(8 * m_beats), emi_wdata, emi_bws);
        end
      end
      if (m_done && !m_cmd.rnw) begin
        for (int b = 0; b < (m_cmd.burst ? BEATS : 1); b++) begin
          logic [63:0] mk_m = m_cmd.burst ? 64'hFFFF_FFFF_FFFF_FFFF : lane_mask(m_cmd.bws);
          chk("wmem", mem_rd64(m_addr + 32'(8 * b)) & mk_m, m_cmd.d[b] & mk_m);
        end
      end
      // monitors of DUT activity used by the literal expectations
      if (rd_valid) begin
        rd_log[rd_beat] = rd_data;
        if (first_rd_beat < 0) first_rd_beat = int'(rd_beat);
      end
      err_cnt += int'(err_spurious);
      done_cnt += int'(done);
      if (emi_req) begin
        if (!prev_req) first_addr = emi_addr;
        if (seen_req && low_run > 0) last_gap = low_run;
        seen_req = 1; low_run = 0;
      end else begin
        low_run++;
      end
      prev_req = emi_req;
    end
  endtask

  task automatic model_update();
    if (!reset) begin
      m_busy = 0; m_done = 0; m_spur = 0; m_beats = 0;
    end else begin
      m_spur = emi_valid && !m_busy;
      m_done = 0;
      if (!m_busy) begin
        if (cmd_valid && cq.size() > 0) begin
          m_cmd   = cq.pop_front();
          m_busy  = 1;
          m_beats = 0;
          m_total = m_cmd.burst ? BEATS : 1;
          m_addr  = m_cmd.burst ? {m_cmd.addr[31:5], 5'b0} : m_cmd.addr;
          m_size  = m_cmd.burst ? 2'b11 : m_cmd.size;
          m_bws   = m_cmd.burst ? 8'hFF : m_cmd.bws;
        end
      end else if (emi_valid) begin
        m_beats++;
        if (m_beats == m_total) begin
          m_busy = 0; m_done = 1; m_beats = 0;
        end
      end
    end
  endtask

  task automatic drive();
    cmd_valid = (cq.size() > 0);
    if (cq.size() > 0) begin
      cmd_rnw = cq[0].rnw; cmd_burst = cq[0].burst; cmd_addr = cq[0].addr;
      cmd_size = cq[0].size; cmd_bws = cq[0].bws;
    end
    emi_valid = force_valid || (m_busy && ($urandom_range(99) < valid_pct));
    emi_rdata = m_busy ? mem_rd64(emi_addr + 32'(8 * m_beats)) : {$urandom, $urandom};
    wr_data   = (m_busy && !m_cmd.rnw) ? m_cmd.d[m_beats] : {$urandom, $urandom};
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    drive();
  endtask

  task automatic wait_idle();
    int budget = 400;
    while ((cq.size() > 0 || m_busy) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: command not completed, got busy expected idle at %0t", $time);
    end
    step(); step();
  endtask

  initial begin
    int d0, e0;
    cmd_t c;
    cmd_valid = 0; cmd_rnw = 0; cmd_burst = 0; cmd_addr = '0; cmd_size = '0; cmd_bws = '0;
    wr_data = '0; emi_rdata = '0; emi_valid = 0;
    step(); step();
    reset = 1;
    step(); step();

    // 1: burst read, no stalls
    for (int i = 0; i < 4; i++) mem_wr64(32'h1234_5660 + 32'(8 * i), 64'hA0 + 64'(i), 8'hFF);
    valid_pct = 100;
    d0 = done_cnt;
    cq.push_back(mk(1, 1, 32'h1234_5678, 2'd0, 8'h00));
    wait_idle();
    chk("t1_addr", first_addr, 32'h1234_5660);
    for (int i = 0; i < 4; i++) chk("t1_rd_data", rd_log[i], 64'hA0 + 64'(i));
    chk("t1_done_count", done_cnt - d0, 1);

    // 2: burst write with stalls
    valid_pct = 40;
    c = mk(0, 1, 32'h4000, 2'd0, 8'h00);
    cq.push_back(c);
    wait_idle();
    for (int i = 0; i < 4; i++) chk("t2_mem", mem_rd64(32'h4000 + 32'(8 * i)), c.d[i]);

    // 3: single 4-byte write to the upper word
    for (int unsigned a = 32'h100; a < 32'h108; a++) mem[a] = 8'hEE;
    valid_pct = 70;
    c = mk(0, 0, 32'h104, 2'd2, 8'hF0);
    c.d[0] = 64'h1122_3344_5566_7788;
    cq.push_back(c);
    wait_idle();
    chk("t3_b104", mem[32'h104], 8'h11); chk("t3_b105", mem[32'h105], 8'h22);
    chk("t3_b106", mem[32'h106], 8'h33); chk("t3_b107", mem[32'h107], 8'h44);
    for (int unsigned a = 32'h100; a < 32'h104; a++) chk("t3_low_word", mem[a], 8'hEE);

    // 4: back-to-back burst read then single read
    valid_pct = 100;
    last_gap = -1;
    cq.push_back(mk(1, 1, 32'h2000, 2'd0, 8'h00));
    cq.push_back(mk(1, 0, 32'h3004, 2'd2, 8'h0F));
    wait_idle();
    chk("t4_gap", last_gap, 1);
    chk("t4_second_addr", first_addr, 32'h3004);

    // 5: reset while beat 2 of a burst read is pending
    begin
      int b = 50;
      cq.push_back(mk(1, 1, 32'h5000, 2'd0, 8'h00));
      while (!(m_busy && m_beats == 2) && b > 0) begin step(); b--; end
      if (b == 0) begin
        n_checks++; n_fail++;
        $display("FAIL t5_reach_beat2: got timeout expected beat 2 at %0t", $time);
      end
      d0 = done_cnt;
      reset = 0; force_valid = 1; emi_valid = 1;
      step(); step();
      force_valid = 0; emi_valid = 0; reset = 1;
      step(); step();
      chk("t5_no_done", done_cnt - d0, 0);
      cq.push_back(mk(1, 1, 32'h5000, 2'd0, 8'h00));
      wait_idle();
      chk("t5_fresh_done", done_cnt - d0, 1);
    end

    // 6: spurious valid while idle
    e0 = err_cnt;
    emi_valid = 1;
    step(); step(); step();
    chk("t6_err_count", err_cnt - e0, 1);
    first_rd_beat = -1;
    cq.push_back(mk(1, 1, 32'h6040, 2'd0, 8'h00));
    wait_idle();
    chk("t6_first_rd_beat", first_rd_beat, 0);

    // randomized commands, stalls and idle spurious pulses
    for (int n = 0; n < 40; n++) begin
      valid_pct = int'($urandom_range(100, 20));
      cq.push_back(mk(1'($urandom), 1'($urandom), 32'h8000 + 32'($urandom_range(4095)),
                      2'($urandom), 8'($urandom)));
      wait_idle();
      for (int k = int'($urandom_range(3)); k > 0; k--) begin
        if ($urandom_range(3) == 0) emi_valid = 1;
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
